// File: rtl/pixel_rx_pkg.sv
// Shared types and constants for the pixel-ingest receive controller.
package pixel_rx_pkg;

  localparam int PIXELS_DEF = 784;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2,
    RECOVER   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/pixel_frame_rx_ctrl_if.sv
// Parallel pixel link between the external sender (master) and the receive controller (slave).
interface pixel_frame_rx_ctrl_if #(
    parameter int DATA_W = 8
);
    // 4-phase handshake: sender holds data stable and raises valid; receiver
    // raises ack; sender drops valid; receiver drops ack. The EOF level's
    // rising edge closes a frame.
    logic [DATA_W-1:0] i_px_data;
    logic              i_px_valid;
    logic              i_px_eof;
    logic              o_px_ack;

    modport master (
        output i_px_data,
        output i_px_valid,
        output i_px_eof,
        input  o_px_ack
    );

    modport slave (
        input  i_px_data,
        input  i_px_valid,
        input  i_px_eof,
        output o_px_ack
    );
endinterface

// File: rtl/pixel_rx_sync.sv
// Multi-stage flip-flop synchronizer with asynchronous active-low reset.
module pixel_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pixel_frame_rx_ctrl.sv
// Receives pixels over a 4-phase link into a frame buffer, holding off the
// sender while a finished frame waits for the CPU.
module pixel_frame_rx_ctrl
    import pixel_rx_pkg::*;
#(
    parameter int PIXELS         = PIXELS_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rstn,
    pixel_frame_rx_ctrl_if.slave link,
    input  logic [CNT_W-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]    o_rd_data,
    input  logic                 i_frame_release,
    input  logic                 i_clr_err,
    output logic                 o_frame_ready,
    output logic [CNT_W-1:0]     o_px_count,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic                 o_short,
    output rx_state_e            o_dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               timeout_q, timeout_d;
    logic               short_q, short_d;
    logic               eof_dly_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               valid_s, eof_s, eof_rise;
    logic               wr_en, set_tmo, set_short;

    logic [DATA_W-1:0]  buf_mem [PIXELS];

    pixel_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_valid (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (link.i_px_valid),
        .q_o  (valid_s)
    );

    pixel_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_eof (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (link.i_px_eof),
        .q_o  (eof_s)
    );

    assign eof_rise = eof_s & ~eof_dly_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            tmo_cnt_q <= '0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            short_q   <= 1'b0;
            eof_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tmo_cnt_q <= tmo_cnt_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            short_q   <= short_d;
            eof_dly_q <= eof_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tmo_cnt_d = tmo_cnt_q;
        ready_d   = ready_q;
        wr_en     = 1'b0;
        set_tmo   = 1'b0;
        set_short = 1'b0;
        case (state_q)
            IDLE: begin
                // EOF outranks a pixel arriving in the same cycle.
                if (eof_rise && (count_q != '0) && !ready_q) begin
                    ready_d   = 1'b1;
                    set_short = (count_q < CNT_W'(PIXELS));
                end else if (valid_s && !ready_q) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    state_d = ACK;
                end
            end
            ACK: begin
                if (count_q == CNT_W'(PIXELS)) ready_d = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!valid_s) begin
                    tmo_cnt_d = '0;
                    state_d   = IDLE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    set_tmo   = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = RECOVER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            RECOVER: begin
                if (!valid_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_frame_release) begin
            ready_d = 1'b0;
            count_d = '0;
        end

        timeout_d = set_tmo   | (timeout_q & ~i_clr_err);
        short_d   = set_short | (short_q   & ~i_clr_err);
        // Ack is exactly "we are in WAIT_DROP", so it lags ACK entry by one cycle.
        ack_d     = (state_d == WAIT_DROP);
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[count_q] <= link.i_px_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (i_rd_addr < CNT_W'(PIXELS)) begin
            rd_data_q <= buf_mem[i_rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign link.o_px_ack = ack_q;
    assign o_rd_data     = rd_data_q;
    assign o_frame_ready = ready_q;
    assign o_px_count    = count_q;
    assign o_busy        = (state_q != IDLE);
    assign o_timeout     = timeout_q;
    assign o_short       = short_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_pixel_frame_rx_ctrl.sv
// Self-checking bench: transaction-level reference model of the pixel receive controller.
module tb_pixel_frame_rx_ctrl;
  import pixel_rx_pkg::*;

  localparam int PIXELS = 784;
  localparam int TMO    = 16;
  localparam int WAIT_N = 24;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pixel_frame_rx_ctrl_if #(.DATA_W(8)) link ();

  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_release = 1'b0;
  logic       clr_err = 1'b0;
  logic       frame_ready, busy, timeout, short_f;
  logic [9:0] px_count;
  rx_state_e  dbg_state;

  pixel_frame_rx_ctrl #(
    .PIXELS(PIXELS), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .link(link.slave),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .i_frame_release(frame_release), .i_clr_err(clr_err),
    .o_frame_ready(frame_ready), .o_px_count(px_count), .o_busy(busy),
    .o_timeout(timeout), .o_short(short_f), .o_dbg_state(dbg_state)
  );

  // reference model state
  logic [7:0] ref_mem [PIXELS];
  bit         ref_known [PIXELS];
  int         ref_count;
  bit         ref_ready, ref_short, ref_tmo;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, output bit seen);
    seen = 0;
    for (int i = 0; i < WAIT_N; i++) begin
      tick();
      if (link.o_px_ack === lvl) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic model_accept(input logic [7:0] d);
    ref_mem[ref_count]   = d;
    ref_known[ref_count] = 1'b1;
    ref_count++;
    if (ref_count == PIXELS) ref_ready = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_count"}, 32'(px_count), 32'(ref_count));
    check_eq({tag, "_ready"}, 32'(frame_ready), 32'(ref_ready));
    check_eq({tag, "_short"}, 32'(short_f), 32'(ref_short));
    check_eq({tag, "_timeout"}, 32'(timeout), 32'(ref_tmo));
  endtask

  // driver tasks
  task automatic send_px(input logic [7:0] d);
    bit seen;
    link.i_px_data  = d;
    link.i_px_valid = 1'b1;
    wait_ack(1'b1, seen);
    if (ref_ready) begin
      check_eq("ack_held_off", 32'(seen), 32'd0);
    end else begin
      check_eq("ack_rise", 32'(seen), 32'd1);
      if (seen) model_accept(d);
    end
    link.i_px_valid = 1'b0;
    wait_ack(1'b0, seen);
    check_eq("ack_fall", 32'(seen), 32'd1);
    repeat (3) tick();
    check_eq("idle_after_px", 32'(busy), 32'd0);
    check_model("px");
  endtask

  task automatic pulse_eof();
    link.i_px_eof = 1'b1;
    repeat (6) tick();
    if (ref_count > 0 && !ref_ready) begin
      ref_ready = 1'b1;
      if (ref_count < PIXELS) ref_short = 1'b1;
    end
    link.i_px_eof = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_release();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    ref_ready = 1'b0;
    ref_count = 0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    ref_short = 1'b0;
    ref_tmo   = 1'b0;
  endtask

  task automatic read_chk(input int addr);
    rd_addr = 10'(addr);
    tick();
    if (addr >= PIXELS) check_eq("rd_oob", 32'(rd_data), 32'd0);
    else if (ref_known[addr]) check_eq($sformatf("rd_%0d", addr), 32'(rd_data), 32'(ref_mem[addr]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n;
    logic [7:0] d;
    link.i_px_data  = '0;
    link.i_px_valid = 1'b0;
    link.i_px_eof   = 1'b0;
    ref_count = 0; ref_ready = 0; ref_short = 0; ref_tmo = 0;
    for (int i = 0; i < PIXELS; i++) ref_known[i] = 1'b0;

    repeat (4) tick();
    check_eq("rst_ack", 32'(link.o_px_ack), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_model("rst");
    rstn = 1'b1;
    repeat (2) tick();

    // full frame of i mod 256
    for (int i = 0; i < PIXELS; i++) begin
      send_px(8'(i));
      repeat ($urandom_range(0, 2)) tick();
    end
    check_eq("full_ready", 32'(frame_ready), 32'd1);
    check_eq("full_count", 32'(px_count), 32'd784);
    check_eq("full_short", 32'(short_f), 32'd0);
    read_chk(0);
    check_eq("rd_addr0_lit", 32'(rd_data), 32'h00);
    read_chk(300);
    check_eq("rd_addr300_lit", 32'(rd_data), 32'h2C);
    read_chk(783);
    check_eq("rd_addr783_lit", 32'(rd_data), 32'h0F);
    read_chk(900);
    for (int i = 0; i < 16; i++) read_chk($urandom_range(0, 1023));
    pulse_release();
    check_model("release1");

    // short frame closed by EOF, then backpressure until release
    for (int i = 0; i < 10; i++) send_px(8'($urandom));
    pulse_eof();
    check_eq("short_ready", 32'(frame_ready), 32'd1);
    check_eq("short_count", 32'(px_count), 32'd10);
    check_eq("short_flag", 32'(short_f), 32'd1);
    d = 8'($urandom);
    link.i_px_data  = d;
    link.i_px_valid = 1'b1;
    wait_ack(1'b1, seen);
    check_eq("backpressure_no_ack", 32'(seen), 32'd0);
    pulse_release();
    check_model("bp_release");
    wait_ack(1'b1, seen);
    check_eq("bp_ack_after_release", 32'(seen), 32'd1);
    if (seen) model_accept(d);
    link.i_px_valid = 1'b0;
    wait_ack(1'b0, seen);
    repeat (3) tick();
    check_model("bp_done");
    read_chk(0);
    pulse_clr();
    check_model("clr_short");

    // EOF with empty frame is ignored
    pulse_release();
    pulse_eof();
    check_eq("eof_empty_ready", 32'(frame_ready), 32'd0);
    check_model("eof_empty");

    // valid and EOF rising together with count=5
    for (int i = 0; i < 5; i++) send_px(8'($urandom));
    link.i_px_data  = 8'($urandom);
    link.i_px_valid = 1'b1;
    link.i_px_eof   = 1'b1;
    wait_ack(1'b1, seen);
    check_eq("eof_vs_valid_no_ack", 32'(seen), 32'd0);
    ref_ready = 1'b1;
    ref_short = 1'b1;
    check_model("eof_vs_valid");
    link.i_px_valid = 1'b0;
    link.i_px_eof   = 1'b0;
    repeat (4) tick();
    read_chk(5);
    pulse_release();
    pulse_clr();
    check_model("eof_vs_valid_clr");

    // stuck valid -> timeout
    d = 8'($urandom);
    link.i_px_data  = d;
    link.i_px_valid = 1'b1;
    wait_ack(1'b1, seen);
    check_eq("tmo_ack_rise", 32'(seen), 32'd1);
    if (seen) model_accept(d);
    n = 0;
    do begin
      n++;
      tick();
    end while (link.o_px_ack === 1'b1 && n < 100);
    check_eq("tmo_ack_cycles", 32'(n), 32'(TMO));
    check_eq("tmo_ack_low", 32'(link.o_px_ack), 32'd0);
    check_eq("tmo_busy_recover", 32'(busy), 32'd1);
    ref_tmo = 1'b1;
    check_model("tmo");
    link.i_px_valid = 1'b0;
    repeat (4) tick();
    check_eq("tmo_idle", 32'(busy), 32'd0);
    check_model("tmo_drop");
    pulse_clr();
    check_model("tmo_clr");

    // async reset during WAIT_DROP
    d = 8'($urandom);
    link.i_px_data  = d;
    link.i_px_valid = 1'b1;
    wait_ack(1'b1, seen);
    if (seen) model_accept(d);
    tick();
    #3 rstn = 1'b0;
    #1 check_eq("rst_async_ack", 32'(link.o_px_ack), 32'd0);
    link.i_px_valid = 1'b0;
    ref_count = 0; ref_ready = 0; ref_short = 0; ref_tmo = 0;
    repeat (2) tick();
    check_eq("rst2_busy", 32'(busy), 32'd0);
    check_eq("rst2_rd_data", 32'(rd_data), 32'd0);
    check_model("rst2");
    rstn = 1'b1;
    repeat (2) tick();
    check_model("rst2_rel");

    // randomized mix of operations
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: send_px(8'($urandom));
        6: pulse_eof();
        7: pulse_release();
        8: pulse_clr();
        default: read_chk($urandom_range(0, 1023));
      endcase
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_frame_rx_ctrl.md
Name: pixel_frame_rx_ctrl

Overview:
- Controller for the external parallel pixel-ingest link on the Nexys A7 PMOD pins: 8-bit data, valid and end-of-frame in, acknowledge out.
- Synchronizes the asynchronous link inputs and runs a full 4-phase valid/ack handshake with a stuck-link timeout.
- Sequences pixels into a 28x28 frame buffer and holds off the sender while a completed frame awaits CPU consumption.
- Sits in the clk_core domain between the pins and the CPU-visible register/IO logic; the CPU reads pixels through a synchronous read port.

Parameters:
- PIXELS, 784, pixels per frame (buffer depth).
- DATA_W, 8, pixel width.
- SYNC_STAGES, 2, flip-flop stages on i_px_valid and i_px_eof (minimum 2).
- TIMEOUT_CYCLES, 1_000_000, cycles allowed in WAIT_DROP before the link is declared stuck.

Ports:
- clk  in  1  core clock (clk_core domain).
- rstn  in  1  asynchronous active-low reset.
- i_px_data  in  DATA_W  raw pixel bus from pins; not synchronized.
- i_px_valid  in  1  asynchronous sender valid.
- i_px_eof  in  1  asynchronous end-of-frame strobe (level, edge-detected).
- o_px_ack  out  1  acknowledge to sender; registered.
- i_rd_addr  in  10  CPU pixel read address.
- o_rd_data  out  DATA_W  pixel at i_rd_addr; 1-cycle latency.
- i_frame_release  in  1  single-cycle pulse: CPU has consumed the frame; rearms the block.
- i_clr_err  in  1  single-cycle pulse: clears o_timeout and o_short.
- o_frame_ready  out  1  a complete frame is held in the buffer.
- o_px_count  out  10  pixels written in the current or held frame.
- o_busy  out  1  FSM not in IDLE.
- o_timeout  out  1  sticky: handshake timeout occurred.
- o_short  out  1  sticky: frame closed by EOF with fewer than PIXELS pixels.

Behaviour:
- Reset: all outputs are 0; FSM enters IDLE; sync chains, edge register and timeout counter clear. Buffer contents are not reset. Async assertion mid-handshake drops o_px_ack immediately.
- valid_s and eof_s are the SYNC_STAGES-synchronized inputs. eof_rise is eof_s AND NOT eof_s delayed one cycle.
- i_px_data is sampled only in IDLE when valid_s=1. This is legal because the sender holds data stable from before valid rises until ack is seen.
- IDLE:
  - If eof_rise and o_px_count>0 and !o_frame_ready: set o_frame_ready; set o_short if count<PIXELS. Pixel acceptance is suppressed that cycle; EOF has priority over valid.
  - Else if valid_s and !o_frame_ready: write i_px_data to buf[count], count+=1, go to ACK.
  - An EOF edge while o_frame_ready=1 or count=0 is ignored.
- ACK: o_px_ack=1 (registered, visible the cycle after entry). If count==PIXELS, set o_frame_ready (auto-complete). Go to WAIT_DROP.
- WAIT_DROP:
  - o_px_ack stays 1; the timeout counter increments each cycle.
  - When valid_s=0: ack goes to 0 next cycle, counter clears, go to IDLE.
  - When counter==TIMEOUT_CYCLES-1 and valid_s still 1: set o_timeout, ack goes to 0, go to RECOVER.
- RECOVER: ack=0; wait for valid_s=0, then go to IDLE. No pixel is written here; the pixel already written stays counted.
- Backpressure: while o_frame_ready=1 the block never asserts ack, so the sender stalls.
- i_frame_release: clears o_frame_ready and count to 0 in any state. If it coincides with an ACK-state auto-complete, release wins and count=0.
- i_clr_err clears only the sticky flags. A set event in the same cycle wins over the clear.
- Read port: o_rd_data <= (i_rd_addr<PIXELS) ? buf[i_rd_addr] : 0, registered. Reads are legal in any state. A same-cycle read/write to one address returns the old data.
- Count width is 10 bits and never exceeds PIXELS; no wrap.

Decomposition:
- Package pixel_rx_pkg: state enum (IDLE, ACK, WAIT_DROP, RECOVER), PIXELS/DATA_W defaults, count-width constant.
- Sub-module pixel_rx_sync: a parameterized SYNC_STAGES-deep synchronizer with async active-low reset, instantiated for valid and eof.
- Buffer: inferred simple dual-port RAM inside the top module, no reset.

Test Plan:
- Send 784 pixels with value (i mod 256) via 4-phase handshake -> o_frame_ready=1 after pixel 783's ACK, o_px_count=784, o_short=0; reads of addr 0/300/783 return 0x00/0x2C/0x0F; addr 900 returns 0.
- Send 10 pixels, then pulse EOF -> o_frame_ready=1, count=10, o_short=1. The next valid gets no ack until i_frame_release, after which count=0 and pixel 0 is accepted.
- Hold valid high indefinitely with TIMEOUT_CYCLES=16 -> ack high for 16 cycles then low, o_timeout=1. Dropping valid returns the FSM to IDLE; i_clr_err clears o_timeout.
- Assert valid and EOF rising in the same synchronized cycle with count=5 -> frame closes at count=5; that pixel is not written and no ack is issued.
- Deassert rstn during WAIT_DROP -> o_px_ack=0 asynchronously; after release all flags=0 and count=0.
- EOF with count=0 -> ignored; o_frame_ready stays 0.
